// File: rtl/game2048_pkg.sv
// game2048_pkg
// Constants and types shared by the 2048 game blocks:
//   DIR_*          one-hot move commands driven onto the controller's direction input
//   GS_*           controller status codes carried on game_state
//   input_state_t  sequencing states of the direction_input front-end
//   is_one_hot     true when exactly one bit of a 4-bit button vector is set
package game2048_pkg;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam logic [1:0] GS_NOT_PLAYING = 2'b00;
    localparam logic [1:0] GS_PLAYING     = 2'b01;
    localparam logic [1:0] GS_WIN         = 2'b10;
    localparam logic [1:0] GS_LOSE        = 2'b11;

    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        ARMED        = 2'd1,
        ISSUE        = 2'd2
    } input_state_t;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
// One push-button bit: two-flop synchronizer followed by a persistence filter.
//   clk, rst  clock and synchronous active-high reset
//   btn       raw asynchronous button level
//   btn_db    debounced level; follows the synchronized level only after it
//             has differed for DEBOUNCE_CYCLES consecutive cycles
//   quiet     synchronizer stages and debounced level are all low, i.e. the
//             button is released with nothing pending in the pipeline
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_db,
    output logic quiet
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Stage p0/p1: metastability guard; sync_p1 is the synchronized level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Persistence filter: any agreement restarts the count, so a glitch
    // shorter than DEBOUNCE_CYCLES never propagates.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            btn_db <= 1'b0;
        end else if (sync_p1 == btn_db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            btn_db <= sync_p1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign quiet = ~sync_p0 & ~sync_p1 & ~btn_db;

endmodule

// File: rtl/direction_input.sv
// direction_input
// Turns four raw buttons into the registered one-hot direction command of the
// 2048 controller. A command is issued for a single debounced press while the
// game is playing, held until the controller leaves playing (accepted) or the
// hold timer expires, and re-armed only after every button is released.
//   clk, rst     clock and synchronous active-high reset
//   btn          raw buttons: bit0 up, bit1 down, bit2 left, bit3 right
//   game_state   controller status (00 not playing, 01 playing, 10 win, 11 lose)
//   direction    registered one-hot command, 0 when idle
//   btn_db       debounced button levels
//   move_count   accepted commands, saturating at 16'hFFFF
//   cmd_timeout  one-cycle pulse when a held command expires unaccepted
module direction_input
    import game2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn,
    input  logic [1:0]  game_state,
    output logic [3:0]  direction,
    output logic [3:0]  btn_db,
    output logic [15:0] move_count,
    output logic        cmd_timeout
);

    localparam int HOLD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]        quiet;
    logic              primed;
    logic              playing;
    logic              press_valid;
    logic              all_released;
    logic [HOLD_W-1:0] hold_cnt;
    input_state_t      state;
    input_state_t      next_state;
    logic              load_cmd;
    logic              accept;
    logic              expire;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn[gi]),
            .btn_db(btn_db[gi]),
            .quiet (quiet[gi])
        );
    end

    assign playing     = (game_state == GS_PLAYING);
    assign press_valid = is_one_hot(btn_db);
    // primed holds off arming for the first cycle after reset, when the
    // synchronizers are still cleared and cannot yet show a button held
    // through reset.
    assign all_released = primed && (quiet == 4'b1111);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_RELEASE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            WAIT_RELEASE: if (all_released) next_state = ARMED;
            ARMED:        if (press_valid && playing) next_state = ISSUE;
            ISSUE:        if (!playing || hold_cnt == HOLD_LAST) next_state = WAIT_RELEASE;
            default:      next_state = WAIT_RELEASE;
        endcase
    end

    // Acceptance is tested first so it wins a tie with the timeout.
    always_comb begin
        load_cmd = (state == ARMED) && press_valid && playing;
        accept   = (state == ISSUE) && !playing;
        expire   = (state == ISSUE) && playing && (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            primed      <= 1'b0;
            direction   <= 4'b0000;
            hold_cnt    <= '0;
            move_count  <= 16'd0;
            cmd_timeout <= 1'b0;
        end else begin
            primed      <= 1'b1;
            cmd_timeout <= expire;
            if (load_cmd) begin
                direction <= btn_db;
                hold_cnt  <= '0;
            end else if (accept || expire) begin
                direction <= 4'b0000;
            end else if (state == ISSUE) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if (accept && move_count != 16'hFFFF) begin
                move_count <= move_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_direction_input.sv
module tb_direction_input;

    localparam int D = 4;
    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn;
    logic [1:0]  game_state;
    logic [3:0]  direction;
    logic [3:0]  btn_db;
    logic [15:0] move_count;
    logic        cmd_timeout;

    direction_input #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .game_state (game_state),
        .direction  (direction),
        .btn_db     (btn_db),
        .move_count (move_count),
        .cmd_timeout(cmd_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  dir;
        logic [3:0]  db;
        logic [15:0] mc;
        logic        to;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: button history as a disagreement streak per bit,
    // command life-cycle as a mode number plus the age of the held command.
    bit [3:0] m_raw1, m_raw2, m_db;
    int       m_streak[4];
    int       m_mode;          // 0 awaiting release, 1 ready, 2 holding
    bit [3:0] m_dir;
    int       m_age;
    int       m_mc;
    bit       m_to;
    bit       m_seen_edge;

    task automatic model_edge();
        bit released, playing;
        if (rst) begin
            m_raw1 = 0; m_raw2 = 0; m_db = 0;
            for (int i = 0; i < 4; i++) m_streak[i] = 0;
            m_mode = 0; m_dir = 0; m_age = 0; m_mc = 0; m_to = 0;
            m_seen_edge = 0;
        end else begin
            released = m_seen_edge && m_raw1 == 0 && m_raw2 == 0 && m_db == 0;
            playing  = (game_state == 2'b01);
            m_to = 0;
            if (m_mode == 0) begin
                if (released) m_mode = 1;
            end else if (m_mode == 1) begin
                if ($countones(m_db) == 1 && playing) begin
                    m_dir = m_db; m_age = 0; m_mode = 2;
                end
            end else begin
                if (!playing) begin
                    m_dir = 0; m_mode = 0;
                    if (m_mc < 65535) m_mc = m_mc + 1;
                end else if (m_age == T - 1) begin
                    m_dir = 0; m_to = 1; m_mode = 0;
                end else begin
                    m_age = m_age + 1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (m_raw2[i] != m_db[i]) begin
                    m_streak[i] = m_streak[i] + 1;
                    if (m_streak[i] == D) begin
                        m_db[i] = m_raw2[i];
                        m_streak[i] = 0;
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
            m_raw2 = m_raw1;
            m_raw1 = btn;
            m_seen_edge = 1;
        end
    endtask

    task automatic step(input int n = 1);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            e.dir = m_dir; e.db = m_db; e.mc = 16'(m_mc); e.to = m_to;
            q.push_back(e);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if (direction !== e.dir || btn_db !== e.db || move_count !== e.mc || cmd_timeout !== e.to) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: dir %b/%b db %b/%b mc %0d/%0d to %b/%b (got/required)",
                         $time, direction, e.dir, btn_db, e.db, move_count, e.mc, cmd_timeout, e.to);
            end
        end
    end

    initial begin
        logic [3:0] pat;
        rst = 1'b1; btn = 4'b0000; game_state = 2'b00;
        step(3);
        check("reset_direction", 32'(direction), 32'h0);
        check("reset_btn_db", 32'(btn_db), 32'h0);
        check("reset_move_count", 32'(move_count), 32'h0);
        check("reset_cmd_timeout", 32'(cmd_timeout), 32'h0);
        rst = 1'b0;
        step(4);

        // single press, issue latency 7, accept on leaving playing
        game_state = 2'b01; btn = 4'b0010;
        step(6);
        check("press_latency_early", 32'(direction), 32'h0);
        step(1);
        check("press_latency_7", 32'(direction), 32'h2);
        btn = 4'b0000;
        step(5);
        check("hold_after_release", 32'(direction), 32'h2);
        game_state = 2'b00;
        step(1);
        check("accept_clears", 32'(direction), 32'h0);
        check("accept_count", 32'(move_count), 32'h1);
        step(12);

        // 3-cycle glitch on left
        game_state = 2'b01; btn = 4'b0100;
        step(3);
        btn = 4'b0000;
        step(10);
        check("glitch_btn_db", 32'(btn_db), 32'h0);
        check("glitch_direction", 32'(direction), 32'h0);

        // two buttons is not a press; releasing one issues the other
        btn = 4'b0101;
        step(10);
        check("double_btn_db", 32'(btn_db), 32'h5);
        check("double_no_cmd", 32'(direction), 32'h0);
        btn = 4'b0100;
        step(7);
        check("single_after_double", 32'(direction), 32'h4);
        game_state = 2'b00;
        step(1);
        btn = 4'b0000;
        step(12);

        // timeout while still playing
        game_state = 2'b01; btn = 4'b1000;
        step(7);
        check("timeout_issue", 32'(direction), 32'h8);
        btn = 4'b0000;
        step(19);
        check("timeout_still_held", 32'(direction), 32'h8);
        check("timeout_no_early_pulse", 32'(cmd_timeout), 32'h0);
        step(1);
        check("timeout_clears", 32'(direction), 32'h0);
        check("timeout_pulse", 32'(cmd_timeout), 32'h1);
        check("timeout_count_kept", 32'(move_count), 32'h2);
        step(1);
        check("timeout_pulse_single", 32'(cmd_timeout), 32'h0);
        step(10);

        // button held through reset
        btn = 4'b0001; rst = 1'b1;
        step(2);
        rst = 1'b0; game_state = 2'b01;
        step(20);
        check("held_through_reset_db", 32'(btn_db), 32'h1);
        check("held_through_reset_no_cmd", 32'(direction), 32'h0);
        btn = 4'b0000;
        step(10);
        btn = 4'b0010;
        step(7);
        check("after_release_press", 32'(direction), 32'h2);
        game_state = 2'b00;
        step(1);
        check("after_release_count", 32'(move_count), 32'h1);
        btn = 4'b0000;
        step(12);

        // reset in the middle of a held command
        game_state = 2'b01; btn = 4'b1000;
        step(7);
        check("pre_reset_cmd", 32'(direction), 32'h8);
        rst = 1'b1;
        step(1);
        check("midissue_reset_dir", 32'(direction), 32'h0);
        check("midissue_reset_mc", 32'(move_count), 32'h0);
        check("midissue_reset_to", 32'(cmd_timeout), 32'h0);
        check("midissue_reset_db", 32'(btn_db), 32'h0);
        rst = 1'b0; btn = 4'b0000;
        step(10);

        // randomized phase
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 5))
                0, 1: pat = 4'b0000;
                2, 3: begin pat = 4'b0001; pat = pat << $urandom_range(0, 3); end
                default: pat = 4'($urandom_range(0, 15));
            endcase
            btn = pat;
            if ($urandom_range(0, 3) == 0) game_state = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 2) == 0) game_state = 2'b01;
            rst = ($urandom_range(0, 59) == 0);
            step($urandom_range(1, 12));
            rst = 1'b0;
        end

        step(2);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
